// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants one of three functional units the common data bus and registers its result/tag.
// Define CDB_ROUND_ROBIN_EN for rotating priority; otherwise port 0 > port 1 > port 2.
module cdb_arbiter (
    input  logic        clk,
    input  logic        nRST,
    input  logic        require0,
    input  logic        require1,
    input  logic        require2,
    input  logic [31:0] result0,
    input  logic [31:0] result1,
    input  logic [31:0] result2,
    input  logic [3:0]  label0,
    input  logic [3:0]  label1,
    input  logic [3:0]  label2,
    output logic        requireAC0,
    output logic        requireAC1,
    output logic        requireAC2,
    output logic        cdbValid,
    output logic [31:0] cdbData,
    output logic [3:0]  cdbLabel
);
    logic [2:0] req;
    logic [2:0] pick;
    logic [2:0] gnt;
    logic [31:0] sel_data;
    logic [3:0]  sel_label;

    assign req = {require2, require1, require0};

`ifdef CDB_ROUND_ROBIN_EN
    logic [1:0] ptr;
    logic [2:0] mask;
    logic [2:0] hi;
    logic [2:0] cand;
    // Requests at or above the pointer win; otherwise wrap to the lowest index.
    assign mask = (ptr == 2'd2) ? 3'b100 : (ptr == 2'd1) ? 3'b110 : 3'b111;
    assign hi   = req & mask;
    assign cand = (|hi) ? hi : req;
    assign pick = cand & (~cand + 3'd1);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)
            ptr <= 2'd0;
        else if (|gnt)
            ptr <= gnt[0] ? 2'd1 : gnt[1] ? 2'd2 : 2'd0;
    end
`else
    assign pick = req & (~req + 3'd1);
`endif

    assign gnt        = nRST ? pick : 3'b000;
    assign requireAC0 = gnt[0];
    assign requireAC1 = gnt[1];
    assign requireAC2 = gnt[2];

    assign sel_data  = ({32{gnt[0]}} & result0) | ({32{gnt[1]}} & result1) | ({32{gnt[2]}} & result2);
    assign sel_label = ({4{gnt[0]}} & label0) | ({4{gnt[1]}} & label1) | ({4{gnt[2]}} & label2);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cdbValid <= 1'b0;
            cdbData  <= 32'h0;
            cdbLabel <= 4'h0;
        end else begin
            cdbValid <= |gnt;
            if (|gnt) begin
                cdbData  <= sel_data;
                cdbLabel <= sel_label;
            end
        end
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 The module SHALL have port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-003 For n = 0, 1, 2, the module SHALL have port requireN, input, 1 bit: functional unit N holds a finished result for the CDB.
REQ-004 For n = 0, 1, 2, the module SHALL have port resultN, input, 32 bits: result from unit N; valid while requireN = 1.
REQ-005 For n = 0, 1, 2, the module SHALL have port labelN, input, 4 bits: reservation-station tag from unit N; valid while requireN = 1.
REQ-006 For n = 0, 1, 2, the module SHALL have port requireACN, output, 1 bit: grant to unit N; combinational; unit N retires its result at the next rising edge.
REQ-007 The module SHALL have port cdbValid, output, 1 bit: the broadcast on cdbData/cdbLabel is valid this cycle.
REQ-008 The module SHALL have port cdbData, output, 32 bits: broadcast result.
REQ-009 The module SHALL have port cdbLabel, output, 4 bits: broadcast tag.

Function
REQ-010 At most one requireACN SHALL be 1 in any cycle.
REQ-011 requireACN SHALL be 1 only when requireN = 1.
REQ-012 If any requireN = 1, exactly one grant SHALL be asserted in the same cycle; grants are combinational from the requireN inputs and the priority state, with zero-cycle latency.
REQ-013 On a rising edge where unit k is granted: cdbValid <= 1, cdbData <= resultk, cdbLabel <= labelk (one-cycle broadcast latency).
REQ-014 On a rising edge with no grant: cdbValid <= 0; cdbData and cdbLabel hold their previous values.
REQ-015 A requester that is not granted SHALL keep requireN, resultN and labelN stable; the arbiter stores no pending request and re-arbitrates every cycle.
REQ-016 Back-to-back grants SHALL be supported, giving one broadcast per cycle with no bubble while any requireN = 1.
REQ-017 A request that drops without being granted SHALL be ignored, with no error or side effect.
REQ-018 The arbiter SHALL NOT inspect label values; a label of 0 SHALL be broadcast like any other value.

Reset
REQ-019 While nRST = 0, asynchronously: cdbValid = 0, cdbData = 32'h0, cdbLabel = 4'h0, rotation pointer = 0.
REQ-020 While nRST = 0, all requireACN SHALL be 0 regardless of the requireN inputs.
REQ-021 A grant issued in the cycle in which reset asserts SHALL be discarded, with no broadcast after reset.
REQ-022 The first rising edge after nRST deasserts SHALL arbitrate normally.

Configuration
REQ-023 The macro CDB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-024 When CDB_ROUND_ROBIN_EN is defined:
- a 2-bit rotation pointer p (values 0..2) SHALL give highest priority to port p, then p+1, then p+2 (mod 3);
- after a grant to port k, p <= (k+1) mod 3;
- with no grant, p is unchanged;
- p SHALL never take the value 3.
REQ-025 When CDB_ROUND_ROBIN_EN is not defined:
- fixed priority SHALL apply: port 0 > port 1 > port 2;
- no pointer register SHALL exist.
REQ-026 The policy SHALL be the only behavioural difference between the two builds.

Verification
REQ-027 Reset then idle: all requireN = 0 for 5 cycles -> cdbValid = 0, cdbData = 0, cdbLabel = 0, all grants 0.
REQ-028 Single request: require1 = 1, result1 = 32'hDEADBEEF, label1 = 4'h5 for one cycle -> requireAC1 = 1 in that cycle; next cycle cdbValid = 1, cdbData = 32'hDEADBEEF, cdbLabel = 5; the cycle after, cdbValid = 0 with data/label held.
REQ-029 Fixed-priority build: all three units request, each drops its request after its grant -> grants in cycle order 0, 1, 2; cdbValid = 1 for three consecutive cycles; broadcast labels match ports 0, 1, 2.
REQ-030 Round-robin build: require0 and require2 held high for 4 cycles from reset -> grants alternate 0, 2, 0, 2; port 2 is never starved.
REQ-031 Round-robin build: pointer wrap; grant to port 2, then all three request -> port 0 granted first.
REQ-032 Reset mid-operation: nRST pulsed low while require0 = 1 is being granted -> cdbValid = 0 immediately; pointer = 0; no broadcast of result0 until a new grant after reset.
